sr_instr_encoder: RTL

Streaming RISC-V instruction encoder for the schoolRISCV core: the inverse of the control decoder. It accepts decoded operation descriptors (op id, register indices, immediate) over a valid/ready stream and emits 32-bit RV32I words with sequential word addresses, ready for writing into instruction memory by a program loader or a self-test generator. It supports exactly the instruction subset the core decodes: ADD, OR, SRL, SLTU, SUB, ADDI, LUI, BEQ, BNE.

---
 rtl/sr_instr_encoder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sr_instr_encoder.sv
// rtl/sr_instr_encoder.sv - streaming RV32I encoder (ADD/OR/SRL/SLTU/SUB/ADDI/LUI/BEQ/BNE) with sequential word addresses
// Optional immediate range checking: define SR_ENCODER_RANGE_CHECK_EN.
module sr_instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic        done,
    output logic        err_seen,
    output logic [15:0] instr_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_addr_q, out_addr_d;
    logic        out_err_q, out_err_d;
    logic        last_q, last_d;
    logic        err_seen_q, err_seen_d;
    logic [15:0] count_q, count_d;

    logic [31:0] enc_instr;
    logic        enc_err;
    logic        accept;
    logic        out_hs;

`ifdef SR_ENCODER_RANGE_CHECK_EN
    logic addi_ok;
    logic lui_ok;
    logic br_ok;
    // In range exactly when the upper bits are a pure sign extension of the field.
    assign addi_ok = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
    assign lui_ok  = (in_imm[31:20] == '0);
    assign br_ok   = ((in_imm[31:12] == '0) || (in_imm[31:12] == '1)) && !in_imm[0];
`else
    logic unused_imm_bits;
    assign unused_imm_bits = ^{in_imm[31:20], in_imm[0]};
`endif

    always_comb begin
        enc_instr = '0;
        enc_err   = 1'b0;
        case (in_op)
            4'd0: enc_instr = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
            4'd1: enc_instr = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, 7'b0110011};
            4'd2: enc_instr = {7'b0000000, in_rs2, in_rs1, 3'b101, in_rd, 7'b0110011};
            4'd3: enc_instr = {7'b0000000, in_rs2, in_rs1, 3'b011, in_rd, 7'b0110011};
            4'd4: enc_instr = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
            4'd5: enc_instr = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
            4'd6: enc_instr = {in_imm[19:0], in_rd, 7'b0110111};
            4'd7, 4'd8: enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                                     2'b00, (in_op == 4'd8), in_imm[4:1], in_imm[11],
                                     7'b1100011};
            default: enc_err = 1'b1;
        endcase
`ifdef SR_ENCODER_RANGE_CHECK_EN
        if (((in_op == 4'd5) && !addi_ok) || ((in_op == 4'd6) && !lui_ok) ||
            (((in_op == 4'd7) || (in_op == 4'd8)) && !br_ok)) begin
            enc_err = 1'b1;
        end
`endif
        if (enc_err) begin
            enc_instr = '0;
        end
    end

    // A pending in_last word blocks further input so nothing is accepted past the program end.
    assign in_ready = (state_q == ST_RUN) && !start && (!out_valid_q || out_ready) &&
                      !(out_valid_q && last_q);
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        out_err_d   = out_err_q;
        last_d      = last_q;
        err_seen_d  = err_seen_q;
        count_d     = count_q;
        if (start) begin
            state_d     = ST_RUN;
            out_valid_d = 1'b0;
            out_addr_d  = BASE_ADDR;
            out_err_d   = 1'b0;
            last_d      = 1'b0;
            err_seen_d  = 1'b0;
            count_d     = '0;
        end else begin
            // out_addr advances on handshake, so a word loaded afterwards already sees its own address.
            if (out_hs) begin
                out_valid_d = 1'b0;
                out_addr_d  = out_addr_q + 32'd4;
                count_d     = count_q + 16'd1;
                err_seen_d  = err_seen_q || out_err_q;
                if (last_q) begin
                    state_d = ST_DONE;
                end
            end
            if (accept) begin
                out_valid_d = 1'b1;
                out_instr_d = enc_instr;
                out_err_d   = enc_err;
                last_d      = in_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= BASE_ADDR;
            out_err_q   <= 1'b0;
            last_q      <= 1'b0;
            err_seen_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
            last_q      <= last_d;
            err_seen_q  <= err_seen_d;
            count_q     <= count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_addr    = out_addr_q;
    assign out_err     = out_err_q;
    assign done        = (state_q == ST_DONE);
    assign err_seen    = err_seen_q;
    assign instr_count = count_q;

endmodule
